// File: rtl/pemstat_pkg.sv
// Shared constants and types for the pemstat RX statistics path.
// Optional jumbo bin: build with PEMSTAT_JUMBO_BIN_EN defined.
package pemstat_pkg;

    // Counter bank geometry
    localparam int unsigned NUM_STATS = 16;
    localparam int unsigned PEND_W    = 3;
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    // Stat index map
    localparam int unsigned STAT_FRAMES_OK = 0;
    localparam int unsigned STAT_BCAST_OK  = 1;
    localparam int unsigned STAT_MCAST_OK  = 2;
    localparam int unsigned STAT_PAUSE_OK  = 3;
    localparam int unsigned STAT_FCS_ERR   = 4;
    localparam int unsigned STAT_UNDERSIZE = 5;
    localparam int unsigned STAT_FRAGMENT  = 6;
    localparam int unsigned STAT_OVERSIZE  = 7;
    localparam int unsigned STAT_B64       = 8;
    localparam int unsigned STAT_B65_127   = 9;
    localparam int unsigned STAT_B128_255  = 10;
    localparam int unsigned STAT_B256_511  = 11;
    localparam int unsigned STAT_B512_1023 = 12;
    localparam int unsigned STAT_B1024_1518 = 13;
    localparam int unsigned STAT_B1519_MAX = 14;
    localparam int unsigned STAT_JUMBO     = 15;

    // Length bin boundaries (bytes, FCS included)
    localparam logic [15:0] LEN_MIN   = 16'd64;
    localparam logic [15:0] LEN_B127  = 16'd127;
    localparam logic [15:0] LEN_B255  = 16'd255;
    localparam logic [15:0] LEN_B511  = 16'd511;
    localparam logic [15:0] LEN_B1023 = 16'd1023;
    localparam logic [15:0] LEN_B1518 = 16'd1518;

    // Captured RX status vector
    typedef struct packed {
        logic        valid;
        logic [15:0] len;
        logic        fcs_err;
        logic        bcast;
        logic        mcast;
        logic        pause;
    } rx_vec_t;

endpackage

// File: rtl/pemstat_pend.sv
// Single-index saturating pending counter: queues events while the counter
// bank is held and drains one per cycle once it is released.
module pemstat_pend
    import pemstat_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic hold,
    input  logic arrival,
    output logic emit,
    output logic lost
);

    logic [PEND_W-1:0] pend_q;
    logic [PEND_W-1:0] pend_d;

    // Next pending count, strobe and loss indication
    always_comb begin
        pend_d = pend_q;
        emit   = 1'b0;
        lost   = 1'b0;
        if (hold) begin
            if (pend_q == PEND_MAX) begin
                lost = arrival;
            end else begin
                pend_d = pend_q + PEND_W'(arrival);
            end
        end else if (pend_q != '0) begin
            emit   = 1'b1;
            pend_d = pend_q - PEND_W'(1) + PEND_W'(arrival);
        end else begin
            emit = arrival;
        end
    end

    // Pending count register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

endmodule

// File: rtl/pemstat_rxdec.sv
// RX statistics event decoder: capture -> classify -> pending store -> strobes.
// Optional jumbo bin (index 15) enabled by defining PEMSTAT_JUMBO_BIN_EN.
module pemstat_rxdec
    import pemstat_pkg::*;
#(
    parameter int unsigned MAX_LEN   = 1522,
    parameter int unsigned JUMBO_MAX = 9018
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stat_en,
    input  logic                 hold,
    input  logic                 rx_vec_valid,
    input  logic [15:0]          rx_vec_len,
    input  logic                 rx_vec_fcs_err,
    input  logic                 rx_vec_bcast,
    input  logic                 rx_vec_mcast,
    input  logic                 rx_vec_pause,
    output logic [NUM_STATS-1:0] stat_inc,
    output logic                 stat_lost,
    input  logic                 lost_clr
);

    localparam logic [15:0] MaxLen = 16'(MAX_LEN);
`ifdef PEMSTAT_JUMBO_BIN_EN
    localparam int unsigned NumActive = NUM_STATS;
    localparam logic [15:0] JumboMax  = 16'(JUMBO_MAX);
    localparam logic [15:0] OverLimit = JumboMax;
`else
    localparam int unsigned NumActive = NUM_STATS - 1;
    localparam logic [15:0] OverLimit = MaxLen;
`endif

    if (JUMBO_MAX < MAX_LEN) begin : g_bad_cfg
        $error("pemstat_rxdec: JUMBO_MAX must be >= MAX_LEN");
    end

    rx_vec_t                cap_q;
    logic [NumActive-1:0]   evt;
    logic [NUM_STATS-1:0]   emit;
    logic [NumActive-1:0]   lost_vec;
    logic [15:0]            len;
    logic                   good;
    logic                   in_range;

    // Stage 0: latch qualified vector, otherwise an empty one
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_q <= '0;
        end else if (rx_vec_valid && stat_en) begin
            cap_q <= '{valid:   1'b1,
                       len:     rx_vec_len,
                       fcs_err: rx_vec_fcs_err,
                       bcast:   rx_vec_bcast,
                       mcast:   rx_vec_mcast,
                       pause:   rx_vec_pause};
        end else begin
            cap_q <= '0;
        end
    end

    // Stage 1: classify the captured vector into an event mask
    always_comb begin
        evt      = '0;
        len      = cap_q.len;
        good     = ~cap_q.fcs_err;
        in_range = (len >= LEN_MIN) && (len <= MaxLen);
        if (cap_q.valid) begin
            evt[STAT_FRAMES_OK]  = good && in_range;
            evt[STAT_BCAST_OK]   = good && cap_q.bcast;
            evt[STAT_MCAST_OK]   = good && cap_q.mcast;
            evt[STAT_PAUSE_OK]   = good && cap_q.pause;
            evt[STAT_FCS_ERR]    = cap_q.fcs_err;
            evt[STAT_UNDERSIZE]  = (len < LEN_MIN) && good;
            evt[STAT_FRAGMENT]   = (len < LEN_MIN) && cap_q.fcs_err;
            evt[STAT_OVERSIZE]   = len > OverLimit;
            // Bins are gated by in_range so a small MAX_LEN truncates them
            evt[STAT_B64]        = in_range && (len == LEN_MIN);
            evt[STAT_B65_127]    = in_range && (len > LEN_MIN) && (len <= LEN_B127);
            evt[STAT_B128_255]   = in_range && (len > LEN_B127) && (len <= LEN_B255);
            evt[STAT_B256_511]   = in_range && (len > LEN_B255) && (len <= LEN_B511);
            evt[STAT_B512_1023]  = in_range && (len > LEN_B511) && (len <= LEN_B1023);
            evt[STAT_B1024_1518] = in_range && (len > LEN_B1023) && (len <= LEN_B1518);
            evt[STAT_B1519_MAX]  = in_range && (len > LEN_B1518);
`ifdef PEMSTAT_JUMBO_BIN_EN
            evt[STAT_JUMBO]      = (len > MaxLen) && (len <= JumboMax);
`endif
        end
    end

    // Per-index pending stores
    for (genvar i = 0; i < NumActive; i++) begin : g_pend
        pemstat_pend u_pend (
            .clk     (clk),
            .reset   (reset),
            .hold    (hold),
            .arrival (evt[i]),
            .emit    (emit[i]),
            .lost    (lost_vec[i])
        );
    end

`ifndef PEMSTAT_JUMBO_BIN_EN
    assign emit[STAT_JUMBO] = 1'b0;
`endif

    // Registered strobes and sticky loss flag (clear wins over a new loss)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_inc  <= '0;
            stat_lost <= 1'b0;
        end else begin
            stat_inc <= emit;
            if (lost_clr) begin
                stat_lost <= 1'b0;
            end else if (|lost_vec) begin
                stat_lost <= 1'b1;
            end
        end
    end

endmodule

// File: doc/pemstat_rxdec.md
# pemstat_rxdec

RX statistics event decoder for the pemstat counter bank. It captures the per-frame RX status vector from the MAC receive path and classifies it by length, address type and FCS status. It then emits one-cycle increment strobes, one per statistics counter, to the downstream 18-bit pemstat counter instances. A per-counter pending store absorbs events while the counter bank is held for host load or clear-on-read, so strobes are deferred instead of lost.

## Interface
- MAX_LEN, 1522: largest frame length, in bytes, counted as normal size.
- JUMBO_MAX, 9018: largest jumbo length. Used only when PEMSTAT_JUMBO_BIN_EN is defined.
- clk  in  1  RX statistics clock.
- reset  in  1  Asynchronous reset, active-high.
- stat_en  in  1  Statistics enable. When 0, incoming vectors are ignored.
- hold  in  1  Counter bank busy (host load or read). When 1, strobes are suppressed and events are queued.
- rx_vec_valid  in  1  One-cycle qualifier for the RX status vector.
- rx_vec_len  in  16  Frame length in bytes, including FCS.
- rx_vec_fcs_err  in  1  FCS mismatch.
- rx_vec_bcast, rx_vec_mcast, rx_vec_pause  in  1 each  Destination class and pause opcode flags.
- stat_inc  out  16  Increment strobes, one cycle wide per event.
- stat_lost  out  1  Sticky flag: an event was dropped because a pending counter saturated.
- lost_clr  in  1  Clears stat_lost.

## Operation
- Stat index map:
  - 0 frames_ok, 1 bcast_ok, 2 mcast_ok, 3 pause_ok, 4 fcs_err.
  - 5 undersize (len<64, FCS good), 6 fragment (len<64, FCS bad), 7 oversize.
  - 8 b64, 9 b65_127, 10 b128_255, 11 b256_511, 12 b512_1023, 13 b1024_1518, 14 b1519_max.
  - 15 jumbo.
- Stage 0 capture: when rx_vec_valid & stat_en, latch the vector. Otherwise latch an empty vector.
- Stage 1 decode: build a 16-bit event mask from the latched vector.
  - frames_ok: FCS good and 64 ≤ len ≤ MAX_LEN.
  - bcast_ok, mcast_ok, pause_ok: require FCS good; the length class does not matter.
  - fcs_err: set for any FCS-bad frame.
  - Length bins 8–14: only for 64 ≤ len ≤ MAX_LEN, regardless of FCS. Exactly one bin fires.
  - b1519_max: 1519..MAX_LEN. If MAX_LEN < 1519 it never fires.
  - oversize: len > MAX_LEN. With PEMSTAT_JUMBO_BIN_EN, oversize is len > JUMBO_MAX instead.
- Pending store: one 3-bit saturating count per index, pend[i]. Per cycle, with arrival a = event[i]:
  - hold=1: emit 0. pend[i] = min(pend[i]+a, 7). If pend[i]=7 and a=1, set stat_lost.
  - hold=0 and pend[i]≠0: emit 1; pend[i] = pend[i]−1+a.
  - hold=0 and pend[i]=0: emit a.
- Emitted bits are registered into stat_inc.
- stat_lost: lost_clr has priority over a new loss in the same cycle.
- Pending events drain even when stat_en=0.
- Reset mid-operation clears the capture register, event mask, all pend[] and all outputs. In-flight events are discarded.

## Timing
- Reset values: stat_inc=0, stat_lost=0, pend[]=0.
- Latency: vector on rx_vec_valid at cycle N → stat_inc at cycle N+2 (hold=0, pending empty).
- Throughput: one vector per cycle, back-to-back, with no stalls.
- hold asserted at cycle N: stat_inc is 0 from cycle N+1 for as long as hold is sampled high.
- Draining: one strobe per index per cycle after hold drops. Indices drain in parallel.
- Index 15 is tied 0 when PEMSTAT_JUMBO_BIN_EN is undefined.

## Configuration
- PEMSTAT_JUMBO_BIN_EN defined:
  - Index 15 counts MAX_LEN < len ≤ JUMBO_MAX.
  - oversize means len > JUMBO_MAX.
  - JUMBO_MAX must be ≥ MAX_LEN.
- PEMSTAT_JUMBO_BIN_EN undefined:
  - Index 15 and its pending store are removed, and stat_inc[15]=0.
  - oversize means len > MAX_LEN.

## Structure
- Shared package pemstat_pkg holds:
  - stat index constants and the counter count;
  - bin boundary constants (64, 127, 255, 511, 1023, 1518);
  - pending-count width (3).
- One sub-module, pemstat_pend: a single-index saturating pending counter with hold/drain logic. It is instantiated per index via generate.

## Test plan
- 64-byte broadcast, FCS good, hold=0 → 2 cycles later stat_inc = bits {0,1,8}, each for one cycle.
- Lengths 1518, 1522, 1523, FCS good, back-to-back:
  - 1518 → {0,13};
  - 1522 → {0,14};
  - 1523 → {7} without the macro, or {15} with it.
- 40-byte FCS-bad → {4,6}. 40-byte FCS-good multicast → {2,5}.
- hold=1 for 12 cycles with nine 100-byte good frames:
  - no strobes during hold;
  - stat_lost=1;
  - after release, bits 0 and 9 pulse for exactly 7 consecutive cycles.
- stat_en=0 with valid vectors → no strobes. Pending events from a prior hold still drain.
- reset asserted while pend[0]=5 → stat_inc=0 immediately, with no drain after release. lost_clr clears stat_lost.
